multicycle_control_unit: RTL

//  Multicycle RISC-V (RV32I subset) controller FSM; parametrised successor to the single-cycle decoder.

---
 rtl/multicycle_control_unit_if.sv | 29 ++
 rtl/multicycle_control_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: controller <-> multicycle datapath signal bundle.
interface multicycle_control_unit_if #(parameter int CNT_W = 32);
  logic [31:0]      instr;
  logic             zero_flg;
  logic             mem_ready;
  logic             mem_req;
  logic             PCWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       ImmSrc;
  logic             illegal;
  logic [CNT_W-1:0] instret;
  modport master (
    input  instr, zero_flg, mem_ready,
    output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instret
  );
  modport slave (
    output instr, zero_flg, mem_ready,
    input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I-subset multicycle controller FSM with trap and instret counter.
module multicycle_control_unit #(
  parameter bit ENABLE_BNE    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  state_t state_q, state_d, dec_next;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [6:0] op;
  logic [2:0] f3, alu_f;
  logic rdy, retire, alu_ok, unused_bits;
  assign op          = bus.instr[6:0];
  assign f3          = bus.instr[14:12];
  assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign rdy         = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign alu_ok      = (f3 == 3'b000) || (f3 == 3'b010) || (f3[2:1] == 2'b11);
  assign alu_f       = (f3 == 3'b000) ? ((state_q == EXECR && bus.instr[30]) ? 3'b001 : 3'b000) :
                       (f3 == 3'b010) ? 3'b101 :
                       (f3 == 3'b110) ? 3'b011 : 3'b010;
  assign bus.ImmSrc  = (op == 7'b0100011) ? 2'b01 :
                       (op == 7'b1100011) ? 2'b10 :
                       (op == 7'b1101111) ? 2'b11 : 2'b00;
  assign bus.illegal = (state_q == TRAP);
  assign bus.instret = instret_q;
  assign retire      = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                       (state_q == MEMWRITE && rdy);
  assign instret_d   = instret_q + CNT_W'(retire);
  always_comb begin
    dec_next = TRAP;
    case (op)
      7'b0000011, 7'b0100011: dec_next = (f3 == 3'b010) ? MEMADR : TRAP;
      7'b0110011:             dec_next = alu_ok ? EXECR : TRAP;
      7'b0010011:             dec_next = alu_ok ? EXECI : TRAP;
      7'b1100011:             dec_next = (f3 == 3'b000 || (ENABLE_BNE && f3 == 3'b001)) ? BRANCH : TRAP;
      7'b1101111:             dec_next = JAL;
      default:                dec_next = TRAP;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:        state_d = rdy ? DECODE : FETCH;
      DECODE:       state_d = dec_next;
      MEMADR:       state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:      state_d = rdy ? MEMWB : MEMREAD;
      MEMWRITE:     state_d = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI: state_d = ALUWB;
      JAL:          state_d = ALUWB;
      MEMWB, ALUWB, BRANCH: state_d = FETCH;
      default:      state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 3'b000;
    case (state_q)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = rdy;
        bus.PCWrite   = rdy;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = rdy;
      end
      EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_f;
      end
      EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_f;
      end
      ALUWB: bus.RegWrite = 1'b1;
      BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = 3'b001;
        bus.PCWrite    = f3[0] ? ~bus.zero_flg : bus.zero_flg;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
    // reset abandons any in-flight access: no strobe may leave in the reset cycle
    if (rst) begin
      bus.mem_req  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end
endmodule
